// File: rtl/mem_bus_if_pkg.sv
// mem_bus_if_pkg: shared widths, load/store opcodes, FSM state encoding and
// opcode decode helpers for the MEM-stage data-bus master.
package mem_bus_if_pkg;

   localparam int REG_W      = 32;   // RegBus
   localparam int REG_ADDR_W = 5;    // RegAddrBus
   localparam int ALUOP_W    = 8;    // AluOpBus

   localparam logic             RST_ENABLE = 1'b1;
   localparam logic             STOP       = 1'b1;
   localparam logic [REG_W-1:0] ZERO_WORD  = '0;

   localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_BUSY = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_t;

   typedef enum logic [1:0] {
      SZ_NONE = 2'd0,
      SZ_BYTE = 2'd1,
      SZ_HALF = 2'd2,
      SZ_WORD = 2'd3
   } acc_size_t;

   typedef struct packed {
      logic      is_mem;
      logic      is_store;
      logic      is_signed;
      acc_size_t size;
   } mem_op_t;

   // Classify an aluop into access size, direction and load extension.
   function automatic mem_op_t decode_op(input logic [ALUOP_W-1:0] op);
      mem_op_t d;
      d.is_mem    = 1'b0;
      d.is_store  = 1'b0;
      d.is_signed = 1'b0;
      d.size      = SZ_NONE;
      case (op)
         EXE_LB_OP:  d = '{1'b1, 1'b0, 1'b1, SZ_BYTE};
         EXE_LBU_OP: d = '{1'b1, 1'b0, 1'b0, SZ_BYTE};
         EXE_LH_OP:  d = '{1'b1, 1'b0, 1'b1, SZ_HALF};
         EXE_LHU_OP: d = '{1'b1, 1'b0, 1'b0, SZ_HALF};
         EXE_LW_OP:  d = '{1'b1, 1'b0, 1'b0, SZ_WORD};
         EXE_SB_OP:  d = '{1'b1, 1'b1, 1'b0, SZ_BYTE};
         EXE_SH_OP:  d = '{1'b1, 1'b1, 1'b0, SZ_HALF};
         EXE_SW_OP:  d = '{1'b1, 1'b1, 1'b0, SZ_WORD};
         default:    d.size = SZ_NONE;
      endcase
      return d;
   endfunction

   // Halfword needs addr[0] = 0, word needs addr[1:0] = 0.
   function automatic logic is_misaligned(input logic [ALUOP_W-1:0] op,
                                          input logic [1:0]         offset);
      mem_op_t d;
      d = decode_op(op);
      return ((d.size == SZ_HALF) && offset[0]) ||
             ((d.size == SZ_WORD) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/mem_bus_if_if.sv
// mem_bus_if_if: req/ack data bus between the MEM stage (master) and memory
// (slave). Request fields are held by the master until ack.
interface mem_bus_if_if;
   import mem_bus_if_pkg::*;

   logic             bus_req_o;
   logic             bus_we_o;
   logic [REG_W-1:0] bus_addr_o;
   logic [3:0]       bus_sel_o;
   logic [REG_W-1:0] bus_wdata_o;
   logic             bus_err_o;
   logic             bus_ack_i;
   logic [REG_W-1:0] bus_rdata_i;

   modport master (
      output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o,
      input  bus_ack_i, bus_rdata_i
   );

   modport slave (
      input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o,
      output bus_ack_i, bus_rdata_i
   );
endinterface

// File: rtl/mem_bus_if_fmt.sv
// mem_fmt: combinational big-endian lane formatter. Produces the byte-lane
// select and replicated store word for an access, and extracts/extends the
// addressed byte or halfword from a read word.
module mem_fmt
   import mem_bus_if_pkg::*;
(
   input  logic [ALUOP_W-1:0] op,
   input  logic [1:0]         offset,
   input  logic [REG_W-1:0]   store_data,
   input  logic [REG_W-1:0]   load_raw,
   output logic               is_mem,
   output logic               is_store,
   output logic [3:0]         sel,
   output logic [REG_W-1:0]   store_word,
   output logic [REG_W-1:0]   load_data
);

   mem_op_t    dec;
   logic [7:0] lanes [4];
   logic [7:0] byte_lane;
   logic [15:0] half_lane;

   assign dec      = decode_op(op);
   assign is_mem   = dec.is_mem;
   assign is_store = dec.is_store;

   // Lane 0 is the most significant byte (big-endian).
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = load_raw[REG_W-1-8*gi -: 8];
   end

   // Lane select, store replication and load extension by access size.
   always_comb begin
      sel        = 4'b0000;
      store_word = ZERO_WORD;
      load_data  = ZERO_WORD;
      byte_lane  = lanes[offset];
      half_lane  = offset[1] ? {lanes[2], lanes[3]} : {lanes[0], lanes[1]};
      case (dec.size)
         SZ_BYTE: begin
            case (offset)
               2'b00:   sel = 4'b1000;
               2'b01:   sel = 4'b0100;
               2'b10:   sel = 4'b0010;
               default: sel = 4'b0001;
            endcase
            store_word = {4{store_data[7:0]}};
            load_data  = {{24{dec.is_signed & byte_lane[7]}}, byte_lane};
         end
         SZ_HALF: begin
            sel        = offset[1] ? 4'b0011 : 4'b1100;
            store_word = {2{store_data[15:0]}};
            load_data  = {{16{dec.is_signed & half_lane[15]}}, half_lane};
         end
         SZ_WORD: begin
            sel        = 4'b1111;
            store_word = store_data;
            load_data  = load_raw;
         end
         default: begin
            sel = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/mem_bus_if.sv
// mem_bus_if: MEM-stage data-bus master. Issues one req/ack access per
// load/store, stalls the pipeline until it completes and then presents the
// write-back fields to MEM/WB until the MEM stage is released.
// Optional feature macro: MEM_ALIGN_EXC_EN (misaligned halfword/word accesses
// raise adel_o/ades_o instead of touching the bus).
module mem_bus_if
   import mem_bus_if_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            stall,
   input  logic [ALUOP_W-1:0]    aluop_i,
   input  logic [REG_W-1:0]      mem_addr_i,
   input  logic [REG_W-1:0]      reg2_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [REG_W-1:0]      wdata_i,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [REG_W-1:0]      wdata_o,
   output logic                  stallreq_o,
   mem_bus_if_if.master          bus
`ifdef MEM_ALIGN_EXC_EN
   ,
   output logic                  adel_o,
   output logic                  ades_o
`endif
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   mem_state_t         state_reg;
   logic               req_reg;
   logic               we_reg;
   logic [REG_W-1:0]   addr_reg;
   logic [3:0]         sel_reg;
   logic [REG_W-1:0]   wdata_reg;
   logic               err_reg;
   logic [REG_W-1:0]   rdata_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [ALUOP_W-1:0] op_reg;
   logic [1:0]         off_reg;
   logic               adel_reg;
   logic               ades_reg;

   logic [ALUOP_W-1:0] fmt_op;
   logic [1:0]         fmt_off;
   logic               fmt_is_mem;
   logic               fmt_is_store;
   logic [3:0]         fmt_sel;
   logic [REG_W-1:0]   fmt_store;
   logic [REG_W-1:0]   fmt_load;
   logic               align_fault;
   logic               timeout_hit;
   logic               unused_stall;

   // Only bit 3 (MEM stage held) concerns this stage.
   assign unused_stall = ^{stall[5:4], stall[2:0]};

   // In IDLE the formatter sees the incoming op; afterwards the latched op,
   // so the load extension stays tied to the access actually performed.
   assign fmt_op  = (state_reg == MEM_IDLE) ? aluop_i : op_reg;
   assign fmt_off = (state_reg == MEM_IDLE) ? mem_addr_i[1:0] : off_reg;

   mem_fmt u_fmt (
      .op         (fmt_op),
      .offset     (fmt_off),
      .store_data (reg2_i),
      .load_raw   (rdata_reg),
      .is_mem     (fmt_is_mem),
      .is_store   (fmt_is_store),
      .sel        (fmt_sel),
      .store_word (fmt_store),
      .load_data  (fmt_load)
   );

`ifdef MEM_ALIGN_EXC_EN
   assign align_fault = is_misaligned(aluop_i, mem_addr_i[1:0]);
`else
   assign align_fault = 1'b0;
`endif

   assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

   // Access FSM: issue, wait for ack or timeout, hold result until released.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_reg <= MEM_IDLE;
         req_reg   <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= ZERO_WORD;
         sel_reg   <= 4'b0000;
         wdata_reg <= ZERO_WORD;
         err_reg   <= 1'b0;
         rdata_reg <= ZERO_WORD;
         cnt_reg   <= '0;
         op_reg    <= '0;
         off_reg   <= 2'b00;
         adel_reg  <= 1'b0;
         ades_reg  <= 1'b0;
      end else begin
         err_reg <= 1'b0;
         case (state_reg)
            MEM_IDLE: begin
               if (fmt_is_mem) begin
                  op_reg  <= aluop_i;
                  off_reg <= mem_addr_i[1:0];
                  cnt_reg <= '0;
                  if (align_fault) begin
                     adel_reg  <= ~fmt_is_store;
                     ades_reg  <= fmt_is_store;
                     state_reg <= MEM_DONE;
                  end else begin
                     req_reg   <= 1'b1;
                     we_reg    <= fmt_is_store;
                     addr_reg  <= {mem_addr_i[REG_W-1:2], 2'b00};
                     sel_reg   <= fmt_sel;
                     wdata_reg <= fmt_store;
                     state_reg <= MEM_BUSY;
                  end
               end
            end
            MEM_BUSY: begin
               if (bus.bus_ack_i) begin
                  rdata_reg <= bus.bus_rdata_i;
                  req_reg   <= 1'b0;
                  state_reg <= MEM_DONE;
               end else if (timeout_hit) begin
                  rdata_reg <= ZERO_WORD;
                  req_reg   <= 1'b0;
                  err_reg   <= 1'b1;
                  state_reg <= MEM_DONE;
               end else if (TIMEOUT != 0) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            MEM_DONE: begin
               if (stall[3] != STOP) begin
                  adel_reg  <= 1'b0;
                  ades_reg  <= 1'b0;
                  state_reg <= MEM_IDLE;
               end
            end
            default: begin
               state_reg <= MEM_IDLE;
            end
         endcase
      end
   end

   assign bus.bus_req_o   = req_reg;
   assign bus.bus_we_o    = we_reg;
   assign bus.bus_addr_o  = addr_reg;
   assign bus.bus_sel_o   = sel_reg;
   assign bus.bus_wdata_o = wdata_reg;
   assign bus.bus_err_o   = err_reg;

`ifdef MEM_ALIGN_EXC_EN
   assign adel_o = (state_reg == MEM_DONE) & adel_reg;
   assign ades_o = (state_reg == MEM_DONE) & ades_reg;
`endif

   // Write-back fields and stall request; loads return data only in DONE.
   always_comb begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = wdata_i;
      stallreq_o = 1'b0;
      case (state_reg)
         MEM_IDLE: stallreq_o = fmt_is_mem;
         MEM_BUSY: stallreq_o = 1'b1;
         MEM_DONE: begin
            if (!fmt_is_store) begin
               wdata_o = fmt_load;
            end
            if (adel_reg | ades_reg) begin
               wreg_o = 1'b0;
            end
         end
         default: stallreq_o = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: randomized and directed checks of the MEM-stage bus master
// against a byte-arithmetic reference model of big-endian load/store rules.
module tb_mem_bus_if;
   import mem_bus_if_pkg::*;

   localparam int unsigned TO     = 4;
   localparam logic [7:0]  NOP_OP = 8'h25;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [7:0]  aluop;
   logic [31:0] mem_addr;
   logic [31:0] reg2;
   logic [4:0]  wd_in;
   logic        wreg_in;
   logic [31:0] wdata_in;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stallreq_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_wdata;
   logic [7:0]  mem_ops [8];

   mem_bus_if_if bus_i ();

   mem_bus_if #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .aluop_i    (aluop),
      .mem_addr_i (mem_addr),
      .reg2_i     (reg2),
      .wd_i       (wd_in),
      .wreg_i     (wreg_in),
      .wdata_i    (wdata_in),
      .wd_o       (wd_o),
      .wreg_o     (wreg_o),
      .wdata_o    (wdata_o),
      .stallreq_o (stallreq_o),
      .bus        (bus_i)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int op_bytes(input logic [7:0] op);
      case (op)
         EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
         default:                          return 4;
      endcase
   endfunction

   function automatic logic op_is_store(input logic [7:0] op);
      return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
   endfunction

   function automatic logic op_signed(input logic [7:0] op);
      return (op == EXE_LB_OP) || (op == EXE_LH_OP);
   endfunction

   // Offset of the first addressed byte within the word, rounded down to size.
   function automatic int first_byte(input logic [7:0] op, input logic [31:0] addr);
      int n;
      n = op_bytes(op);
      return int'(addr[1:0]) & ~(n - 1);
   endfunction

   function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] addr);
      int n;
      int lanes;
      n = op_bytes(op);
      lanes = ((1 << n) - 1) << (4 - n - first_byte(op, addr));
      return lanes[3:0];
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] d);
      case (op_bytes(op))
         1:       return d[7:0] * 32'h0101_0101;
         2:       return d[15:0] * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] addr,
                                            input logic [31:0] raw);
      int          n;
      int          shift;
      logic [63:0] v;
      logic [63:0] lim;
      n     = op_bytes(op);
      shift = 8 * (4 - n - first_byte(op, addr));
      v     = {32'h0, raw} >> shift;
      lim   = 64'h1 << (8 * n);
      v     = v & (lim - 64'h1);
      if (op_signed(op) && v[8*n-1]) v = v | ~(lim - 64'h1);
      return v[31:0];
   endfunction

   // ---------------- one complete access, checked cycle by cycle ----------------
   task automatic do_access(input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rd,
                            input int delay, input int hold, input string tag);
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [31:0] e_result;
      logic [3:0]  e_sel;
      logic        e_we;
      int          n_stall;
      aluop    = op;
      mem_addr = addr;
      reg2     = data;
      wd_in    = 5'($urandom);
      wreg_in  = 1'($urandom);
      wdata_in = $urandom;
      stall    = 6'b0;
      e_addr   = addr & 32'hFFFF_FFFC;
      e_sel    = exp_sel(op, addr);
      e_wdata  = exp_wdata(op, data);
      e_we     = op_is_store(op);
      e_result = e_we ? wdata_in : exp_load(op, addr, rd);
      n_stall  = 0;

      @(negedge clk);
      checks++;
      if (stallreq_o !== 1'b1 || bus_i.bus_req_o !== 1'b0) begin
         errors++;
         $display("FAIL %s issue: stallreq=%b req=%b required stallreq=1 req=0",
                  tag, stallreq_o, bus_i.bus_req_o);
      end
      if (stallreq_o === 1'b1) n_stall++;
      @(posedge clk); #1;

      for (int i = 0; i <= delay; i++) begin
         @(negedge clk);
         checks++;
         if ({bus_i.bus_req_o, bus_i.bus_we_o, bus_i.bus_addr_o, bus_i.bus_sel_o,
              bus_i.bus_wdata_o, bus_i.bus_err_o} !== {1'b1, e_we, e_addr, e_sel, e_wdata, 1'b0}) begin
            errors++;
            $display("FAIL %s busy%0d: req=%b we=%b addr=%h sel=%b wdata=%h err=%b required req=1 we=%b addr=%h sel=%b wdata=%h err=0",
                     tag, i, bus_i.bus_req_o, bus_i.bus_we_o, bus_i.bus_addr_o, bus_i.bus_sel_o,
                     bus_i.bus_wdata_o, bus_i.bus_err_o, e_we, e_addr, e_sel, e_wdata);
         end
         if (stallreq_o === 1'b1) n_stall++;
         if (i == delay) begin
            bus_i.bus_ack_i   = 1'b1;
            bus_i.bus_rdata_i = rd;
         end
         @(posedge clk); #1;
      end

      // ack left asserted with different data: must be ignored outside BUSY
      bus_i.bus_rdata_i = ~rd;
      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         checks++;
         if (wdata_o !== e_result || wd_o !== wd_in || wreg_o !== wreg_in ||
             stallreq_o !== 1'b0 || bus_i.bus_req_o !== 1'b0) begin
            errors++;
            $display("FAIL %s done%0d: wdata_o=%h wd_o=%0d wreg_o=%b stallreq=%b req=%b required wdata_o=%h wd_o=%0d wreg_o=%b stallreq=0 req=0",
                     tag, h, wdata_o, wd_o, wreg_o, stallreq_o, bus_i.bus_req_o,
                     e_result, wd_in, wreg_in);
         end
         last_wdata = wdata_o;
         stall = (h < hold) ? 6'b00_1111 : 6'b0;
         @(posedge clk); #1;
      end

      bus_i.bus_ack_i = 1'b0;
      stall    = 6'b0;
      aluop    = NOP_OP;
      wdata_in = $urandom;
      @(negedge clk);
      checks++;
      if (bus_i.bus_req_o !== 1'b0 || stallreq_o !== 1'b0 || wdata_o !== wdata_in) begin
         errors++;
         $display("FAIL %s idle: req=%b stallreq=%b wdata_o=%h required req=0 stallreq=0 wdata_o=%h",
                  tag, bus_i.bus_req_o, stallreq_o, wdata_o, wdata_in);
      end
      checks++;
      if (n_stall != delay + 2) begin
         errors++;
         $display("FAIL %s stall_cycles: got %0d required %0d", tag, n_stall, delay + 2);
      end
      $display("txn %s op=%h addr=%h data=%h rd=%h delay=%0d hold=%0d result=%h",
               tag, op, addr, data, rd, delay, hold, last_wdata);
      @(posedge clk); #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      stall = 6'b0; aluop = NOP_OP; mem_addr = 32'h0; reg2 = 32'h0;
      wd_in = 5'd0; wreg_in = 1'b0; wdata_in = 32'h0;
      bus_i.bus_ack_i = 1'b0; bus_i.bus_rdata_i = 32'h0;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({bus_i.bus_req_o, bus_i.bus_we_o, bus_i.bus_err_o, bus_i.bus_addr_o,
           bus_i.bus_sel_o, bus_i.bus_wdata_o, stallreq_o} !== 71'h0) begin
         errors++;
         $display("FAIL reset: req=%b we=%b err=%b addr=%h sel=%b wdata=%h stallreq=%b required all 0",
                  bus_i.bus_req_o, bus_i.bus_we_o, bus_i.bus_err_o, bus_i.bus_addr_o,
                  bus_i.bus_sel_o, bus_i.bus_wdata_o, stallreq_o);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      $display("txn reset released");
   endtask

   task automatic test_passthrough();
      for (int k = 0; k < 4; k++) begin
         aluop    = 8'($urandom_range(0, 8'hDF));
         wd_in    = 5'($urandom);
         wreg_in  = 1'($urandom);
         wdata_in = $urandom;
         @(negedge clk);
         checks++;
         if (wd_o !== wd_in || wreg_o !== wreg_in || wdata_o !== wdata_in || stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL passthrough: wd_o=%0d wreg_o=%b wdata_o=%h stallreq=%b required %0d %b %h 0",
                     wd_o, wreg_o, wdata_o, stallreq_o, wd_in, wreg_in, wdata_in);
         end
         @(posedge clk); #1;
         checks++;
         if (bus_i.bus_req_o !== 1'b0) begin
            errors++;
            $display("FAIL passthrough_req: req=%b required 0", bus_i.bus_req_o);
         end
         $display("txn passthrough op=%h wdata=%h", aluop, wdata_in);
      end
      aluop = NOP_OP;
   endtask

   task automatic test_lb_lbu();
      do_access(EXE_LB_OP, 32'h0000_0103, 32'h0, 32'h1122_3384, 0, 0, "lb");
      checks++;
      if (last_wdata !== 32'hFFFF_FF84) begin
         errors++;
         $display("FAIL lb_value: got %h required ffffff84", last_wdata);
      end
      do_access(EXE_LBU_OP, 32'h0000_0103, 32'h0, 32'h1122_3384, 0, 0, "lbu");
      checks++;
      if (last_wdata !== 32'h0000_0084) begin
         errors++;
         $display("FAIL lbu_value: got %h required 00000084", last_wdata);
      end
   endtask

   task automatic test_sh();
      do_access(EXE_SH_OP, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0, 0, "sh");
   endtask

   task automatic test_sw_wait();
      do_access(EXE_SW_OP, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 2, 0, "sw_wait");
   endtask

   task automatic test_lw_hold();
      do_access(EXE_LW_OP, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 1, 2, "lw_hold");
      checks++;
      if (last_wdata !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL lw_hold_value: got %h required cafef00d", last_wdata);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         do_access(mem_ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2), "rand");
      end
   endtask

   task automatic test_rst_busy();
      aluop = EXE_LW_OP; mem_addr = 32'h0000_0800; stall = 6'b0;
      @(posedge clk); #1;
      @(negedge clk);
      rst   = 1'b1;
      aluop = NOP_OP;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bus_i.bus_req_o !== 1'b0 || stallreq_o !== 1'b0 || bus_i.bus_addr_o !== 32'h0 ||
          bus_i.bus_sel_o !== 4'b0 || bus_i.bus_wdata_o !== 32'h0 || bus_i.bus_we_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy: req=%b stallreq=%b addr=%h sel=%b wdata=%h we=%b required all 0",
                  bus_i.bus_req_o, stallreq_o, bus_i.bus_addr_o, bus_i.bus_sel_o,
                  bus_i.bus_wdata_o, bus_i.bus_we_o);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      $display("txn rst_busy abandoned");
   endtask

   task automatic test_timeout();
      aluop = EXE_LW_OP; mem_addr = 32'h0000_0404; wreg_in = 1'b1; wdata_in = $urandom;
      stall = 6'b0; bus_i.bus_ack_i = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < int'(TO); i++) begin
         @(negedge clk);
         checks++;
         if (bus_i.bus_req_o !== 1'b1 || bus_i.bus_err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy%0d: req=%b err=%b required req=1 err=0",
                     i, bus_i.bus_req_o, bus_i.bus_err_o);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (bus_i.bus_err_o !== 1'b1 || bus_i.bus_req_o !== 1'b0 || wdata_o !== 32'h0 || stallreq_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_abort: err=%b req=%b wdata_o=%h stallreq=%b required err=1 req=0 wdata_o=0 stallreq=0",
                  bus_i.bus_err_o, bus_i.bus_req_o, wdata_o, stallreq_o);
      end
      @(posedge clk); #1;
      aluop = NOP_OP;
      @(negedge clk);
      checks++;
      if (bus_i.bus_err_o !== 1'b0 || bus_i.bus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_after: err=%b req=%b stallreq=%b required 0 0 0",
                  bus_i.bus_err_o, bus_i.bus_req_o, stallreq_o);
      end
      $display("txn timeout after %0d busy cycles", TO);
      @(posedge clk); #1;
   endtask

   initial begin
      mem_ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                  EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
      last_wdata = 32'h0;
      test_reset();
      test_passthrough();
      test_lb_lbu();
      test_sh();
      test_sw_wait();
      test_lw_hold();
      test_random();
      test_rst_busy();
      test_lb_lbu();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- MEM-stage data-bus master of the 5-stage MIPS pipeline.
- Consumes the aluop/address/store-data fields registered by the EX/MEM pipeline register and performs LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data bus.
- Stalls the pipeline via stallreq_o until the access completes, then hands the write-back fields to MEM/WB.

Parameters:
- TIMEOUT, 255, BUSY cycles without ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  6  pipeline stall vector; bit 3 = MEM stage held
- aluop_i  in  8  operation code
- mem_addr_i  in  32  byte address
- reg2_i  in  32  store data
- wd_i  in  5  destination register
- wreg_i  in  1  write-back enable
- wdata_i  in  32  non-load result
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- stallreq_o  out  1  to stall controller
- bus_req_o  out  1  access request
- bus_we_o  out  1  1 = store
- bus_addr_o  out  32  word address, low two bits 0
- bus_sel_o  out  4  byte lanes, big-endian (bit 3 = bits 31:24)
- bus_wdata_o  out  32  store data
- bus_ack_i  in  1  access complete
- bus_rdata_i  in  32  read data, valid with ack
- bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- FSM states:
  - IDLE: no access pending.
  - BUSY: bus access outstanding.
  - DONE: result held until the pipeline advances.
- Reset: state IDLE; bus_req_o, bus_we_o, bus_err_o = 0; bus_addr_o, bus_sel_o, bus_wdata_o = 0; read latch = 0; timeout counter = 0.
- Reset mid-BUSY abandons the request at that edge. The bus must tolerate an abandoned request.
- IDLE, non-memory aluop:
  - wd_o/wreg_o/wdata_o pass through combinationally; stallreq_o = 0.
  - A memory aluop in IDLE drives stallreq_o = 1 combinationally.
- IDLE -> BUSY: taken on the edge when aluop_i is a memory op.
  - At that edge register bus_req_o = 1, bus_we_o, bus_addr_o = {addr[31:2], 2'b00}, bus_sel_o and bus_wdata_o.
- BUSY:
  - stallreq_o = 1.
  - All bus outputs held stable until bus_ack_i = 1.
  - On ack: capture bus_rdata_i, bus_req_o <= 0, go to DONE.
- DONE:
  - stallreq_o = 0.
  - Loads: wdata_o = extended captured data. Stores: wdata_o = wdata_i.
  - If stall[3] = 0 at the edge, go to IDLE; otherwise remain in DONE and do not reissue.
- Minimum latency: 3 cycles (IDLE, BUSY with same-cycle ack, DONE).
- Lane selection by addr[1:0] (big-endian):
  - Byte: 00 -> 1000, 01 -> 0100, 10 -> 0010, 11 -> 0001.
  - Halfword: addr[1] = 0 -> 1100; addr[1] = 1 -> 0011.
  - Word: 1111.
- Store data: byte replicated ×4; halfword replicated ×2; word as-is.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned address (feature off): addr[0] ignored for halfword, addr[1:0] ignored for word.
- Timeout:
  - The counter increments each BUSY cycle without ack.
  - When it reaches TIMEOUT: drop req, load data = 0, pulse bus_err_o for one cycle, go to DONE.
- Ack outside BUSY is ignored.

Optional Feature:
- Macro: MEM_ALIGN_EXC_EN.
- Defined:
  - Misaligned LH/LHU/SH (addr[0] = 1) or LW/SW (addr[1:0] ≠ 0) issues no bus access.
  - The FSM goes IDLE -> DONE directly.
  - Adds output ports adel_o (misaligned load) and ades_o (misaligned store), asserted in DONE; wreg_o forced to 0.
- Undefined: ports absent; low address bits are ignored as described under Behaviour.

Decomposition:
- Shared defines (de.v) hold:
  - EXE_*_OP load/store codes.
  - RegBus, RegAddrBus, AluOpBus widths.
  - RstEnable, Stop, ZeroWord.
  - New FSM state encodings MEM_IDLE, MEM_BUSY, MEM_DONE.
- One combinational sub-module, mem_fmt: lane select, store replication and load extension.

Test Plan:
- LB at 0x103, ack next cycle, rdata 0x11223384 -> sel 0001, wdata_o 0xFFFFFF84; LBU same access -> 0x00000084.
- SH at 0x202, reg2 0x0000ABCD -> bus_addr 0x200, sel 0011, bus_wdata 0xABCDABCD, we 1, wreg_o passes wreg_i.
- SW at 0x300, reg2 0xDEADBEEF, ack on 3rd BUSY cycle -> req and fields stable 3 cycles, stallreq_o high 4 cycles, then DONE.
- LW completes while stall[3] held 2 extra cycles -> remains DONE, no second req, wdata_o stable; advances to IDLE when stall[3] = 0.
- rst during BUSY -> next cycle bus_req_o 0, state IDLE; with TIMEOUT = 4 and no ack -> bus_err_o pulse after 4 BUSY cycles, load data 0.
- With MEM_ALIGN_EXC_EN: LW at 0x101 -> no req, adel_o 1, wreg_o 0.
